id_stage_ctrl: RTL
==================

# id_stage_ctrl

Instruction-decode stage controller between fetch and execute. Accepts instructions over a valid/ready handshake, classifies the opcode, generates the sign-extended immediate, and holds the result in a 2-entry skid buffer. It presents decoded entries to execute with its own valid/ready handshake and supports a single-cycle pipeline flush on branch/jump redirect.

## Interface
- No parameters.
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drops all buffered entries; highest priority.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_imm  out  32  head immediate.
- out_itype  out  3  head immediate class (imm_type_t).
- out_illegal  out  1  head opcode unrecognised (see Configuration).

## Operation
- Accept = in_valid && in_ready && !flush. Consume = out_valid && out_ready && !flush.
- Immediate classification on in_inst[6:0], computed at accept and stored with the entry:
  - 0000011 load: IT_I, sext(inst[31:20]).
  - 0010011 ALU-imm: if inst[14:12]==101, IT_SHAMT, {27'b0, inst[24:20]}; otherwise IT_I, sext(inst[31:20]).
  - 0100011 store: IT_S, sext({inst[31:25], inst[11:7]}).
  - 1100011 branch: IT_B, sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 1101111 jal: IT_J, sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 1100111 jalr: IT_JR, sext(inst[31:20]).
  - Any other opcode: IT_NONE, 0.
- FSM, state register only:
  - EMPTY: out_valid=0, in_ready=1. Accept moves to ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept with consume: stay in ONE; the new entry becomes head.
    - Accept only: go to FULL; the new entry goes to the skid slot.
    - Consume only: go to EMPTY.
  - FULL: out_valid=1, in_ready=0. Consume moves the skid entry to head and goes to ONE.
- flush from any state: next state EMPTY; same-cycle accept and consume are both suppressed.
- Order is strict FIFO; no entry is dropped or duplicated except by flush or reset.

## Timing
- Reset values: state EMPTY; out_valid=0; all data outputs 0; in_ready=0 while reset is high, 1 in the first cycle after.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 when the buffer was EMPTY.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from out_ready or in_valid.
- Sustained throughput is 1 instr/cycle with out_ready held high.
- Output data is stable while out_valid && !out_ready.
- Reset mid-operation discards all entries at the next edge; flush and reset may coincide with identical results.

## Configuration
- ID_ILLEGAL_DETECT_EN defined: out_illegal=1 for a head entry whose opcode is outside {0000011, 0010011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0110011, 1110011}; the flag is stored per entry.
- ID_ILLEGAL_DETECT_EN undefined: out_illegal is tied to 0 and no storage is added.

## Structure
- Shared package id_pkg holds:
  - imm_type_t (3-bit enum: IT_NONE=0, IT_I=1, IT_S=2, IT_B=3, IT_J=4, IT_JR=5, IT_SHAMT=6);
  - opcode localparams;
  - the id_entry_t struct {inst, pc, imm, itype, illegal}.
- One sub-module, id_imm_decode: combinational opcode classifier and immediate extractor, instantiated once on the input side.

## Test plan
- Immediate classes, one per test:
  - 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, IT_I.
  - 0x4030D093 (srai 3) -> imm 0x00000003, IT_SHAMT.
  - 0xFE112E23 (sw -4) -> imm 0xFFFFFFFC, IT_S.
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFF8, IT_B.
- Backpressure: push 3 instructions with out_ready=0.
  - in_ready drops after the 2nd.
  - Release out_ready -> the three entries emerge in order with PCs 0x0, 0x4, 0x8.
- Streaming: out_ready=1 with a valid instruction every cycle -> one output per cycle and state stays ONE.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered instruction is not accepted.
- Reset asserted in FULL -> outputs 0, out_valid=0; in_ready returns to 1 one cycle after reset deasserts.
- Opcode 0x7F with ID_ILLEGAL_DETECT_EN defined -> out_illegal=1, imm 0, IT_NONE; without the macro out_illegal=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage types: immediate classes, opcode constants and the buffered entry layout.
package id_pkg;

    typedef enum logic [2:0] {
        IT_NONE  = 3'd0,
        IT_I     = 3'd1,
        IT_S     = 3'd2,
        IT_B     = 3'd3,
        IT_J     = 3'd4,
        IT_JR    = 3'd5,
        IT_SHAMT = 3'd6
    } imm_type_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 of the right-shift-immediate group, whose immediate is a 5-bit shift amount
    localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_type_t   itype;
        logic        illegal;
    } id_entry_t;

    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        known = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_JAL,
            OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_SYSTEM: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/id_imm_decode.sv
// Combinational opcode classifier and sign-extended immediate extractor.
// Illegal-opcode flag is produced only when ID_ILLEGAL_DETECT_EN is defined.
module id_imm_decode
    import id_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [31:0] o_imm,
    output imm_type_t   o_itype,
    output logic        o_illegal
);

    always_comb begin
        o_imm   = 32'd0;
        o_itype = IT_NONE;
        case (i_inst[6:0])
            OPC_LOAD: begin
                o_itype = IT_I;
                o_imm   = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_OP_IMM: begin
                if (i_inst[14:12] == F3_SHIFT_RIGHT) begin
                    o_itype = IT_SHAMT;
                    o_imm   = {27'd0, i_inst[24:20]};
                end else begin
                    o_itype = IT_I;
                    o_imm   = {{20{i_inst[31]}}, i_inst[31:20]};
                end
            end
            OPC_STORE: begin
                o_itype = IT_S;
                o_imm   = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_BRANCH: begin
                o_itype = IT_B;
                o_imm   = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_JAL: begin
                o_itype = IT_J;
                o_imm   = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                o_itype = IT_JR;
                o_imm   = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            default: begin
                o_itype = IT_NONE;
                o_imm   = 32'd0;
            end
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    assign o_illegal = !opcode_known(i_inst[6:0]);
`else
    assign o_illegal = 1'b0;
`endif

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode stage: classifies incoming instructions and holds them in a 2-entry skid buffer
// (head + skid) with flush support. Optional illegal-opcode flag: ID_ILLEGAL_DETECT_EN.
module id_stage_ctrl
    import id_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [2:0]  out_itype,
    output logic        out_illegal
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    id_entry_t   r_head;
    id_entry_t   r_skid;
    id_entry_t   w_new;
    logic [31:0] w_imm;
    imm_type_t   w_itype;
    logic        w_illegal;
    logic        w_accept;
    logic        w_consume;
    logic        w_head_from_in;
    logic        w_head_from_skid;
    logic        w_skid_from_in;

    id_imm_decode u_imm_decode (
        .i_inst    (in_inst),
        .o_imm     (w_imm),
        .o_itype   (w_itype),
        .o_illegal (w_illegal)
    );

    assign w_new = '{inst: in_inst, pc: in_pc, imm: w_imm, itype: w_itype, illegal: w_illegal};

    // Handshake outputs depend only on registered state (and reset), never on the peer's valid/ready.
    assign in_ready  = (r_state != ST_FULL) && !reset;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_consume = out_valid && out_ready && !flush;

    always_comb begin
        w_state_next     = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_head_from_in = 1'b1;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_head_from_in = 1'b1;
                    end else if (w_accept) begin
                        w_skid_from_in = 1'b1;
                        w_state_next   = ST_FULL;
                    end else if (w_consume) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_head_from_skid = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_head_from_in) begin
                r_head <= w_new;
            end else if (w_head_from_skid) begin
                r_head <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= w_new;
            end
        end
    end

    assign out_inst    = r_head.inst;
    assign out_pc      = r_head.pc;
    assign out_imm     = r_head.imm;
    assign out_itype   = r_head.itype;
    assign out_illegal = r_head.illegal;

endmodule
